// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

   localparam int DATA_W          = 16;
   localparam int DEFAULT_DEPTH   = 1024;
   localparam int DEFAULT_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the CPU MEM stage (master) and the
// data-memory responder (slave).
interface dmem_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [15:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Word store for the responder: synchronous write, registered read.
// Contents are deliberately not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed access latency.
// Define DMEM_MISALIGN_CHECK_EN to fault odd byte addresses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic  clk,
   input  logic  rst_n,
   dmem_if.slave bus_if
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   state_t            state_q,     state_d;
   logic [CW-1:0]     cnt_q,       cnt_d;
   logic              write_q,     write_d;
   logic [AW-1:0]     idx_q,       idx_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              err_q,       err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   logic              out_of_range;
   logic              misaligned;
   logic              req_err;
   logic [AW-1:0]     req_idx;
   logic [AW-1:0]     rd_idx;
   logic [DATA_W-1:0] rd_data;
   logic              mem_we;

   assign out_of_range = (32'(bus_if.req_addr >> 1) >= 32'(DEPTH));
   assign req_idx      = bus_if.req_addr[AW:1];

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misaligned = bus_if.req_addr[0];
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = bus_if.req_addr[0];
   assign misaligned      = 1'b0;
`endif

   assign req_err = out_of_range | misaligned;

   // Reading the incoming address while idle makes the data ready in time
   // for the shortest latency; afterwards the latched index keeps it fresh.
   assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .raddr_i (rd_idx),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_we      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus_if.req_valid) begin
               write_d = bus_if.req_write;
               idx_d   = req_idx;
               wdata_d = bus_if.req_wdata;
               err_d   = req_err;
               cnt_d   = CW'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               mem_we      = write_q & ~err_q;
               rsp_rdata_d = (write_q | err_q) ? '0 : rd_data;
               rsp_err_d   = err_q;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (bus_if.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Ready is gated by reset directly so it reads 0 throughout reset.
   assign bus_if.req_ready = (state_q == IDLE) & rst_n;
   assign bus_if.rsp_valid = (state_q == RESP);
   assign bus_if.rsp_rdata = rsp_rdata_q;
   assign bus_if.rsp_err   = rsp_err_q;

endmodule
